// File: rtl/decode_buffer.sv
// Decoded-instruction buffer: a small circular FIFO between decoder and issue.
// Accepting an entry with a misconduct code blocks further pushes until the buffer is flushed.
module decode_buffer #(
  parameter int DEPTH   = 4,
  parameter int PWIDTH  = 21,
  parameter int FWIDTH  = 3,
  parameter int RFWIDTH = 5,
  parameter int SCWIDTH = 4,
  parameter int ICWIDTH = 6,
  parameter int IMWIDTH = 2,
  parameter logic [IMWIDTH-1:0] IMISCON_FREE = '0
) (
  input  logic                         s_clk_i,
  input  logic                         s_resetn_i,
  input  logic                         s_flush_i,
  input  logic                         s_push_i,
  input  logic [PWIDTH-1:0]            s_payload_i,
  input  logic [FWIDTH-1:0]            s_f_i,
  input  logic [RFWIDTH-1:0]           s_rs1_i,
  input  logic [RFWIDTH-1:0]           s_rs2_i,
  input  logic [RFWIDTH-1:0]           s_rd_i,
  input  logic [SCWIDTH-1:0]           s_sctrl_i,
  input  logic [ICWIDTH-1:0]           s_ictrl_i,
  input  logic [IMWIDTH-1:0]           s_imiscon_i,
  output logic                         s_ready_o,
  output logic                         s_valid_o,
  input  logic                         s_pop_i,
  output logic [PWIDTH-1:0]            s_payload_o,
  output logic [FWIDTH-1:0]            s_f_o,
  output logic [RFWIDTH-1:0]           s_rs1_o,
  output logic [RFWIDTH-1:0]           s_rs2_o,
  output logic [RFWIDTH-1:0]           s_rd_o,
  output logic [SCWIDTH-1:0]           s_sctrl_o,
  output logic [ICWIDTH-1:0]           s_ictrl_o,
  output logic [IMWIDTH-1:0]           s_imiscon_o,
  output logic [$clog2(DEPTH+1)-1:0]   s_count_o,
  output logic                         s_blocked_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int EW   = PWIDTH + FWIDTH + 3*RFWIDTH + SCWIDTH + ICWIDTH + IMWIDTH;

  logic [PTRW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0] count_reg;
  logic            blocked_reg;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head_entry;
  logic            full, push_acc, pop_acc;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH-1)) ? '0 : p + PTRW'(1);
  endfunction

  // Ready depends only on registered state, so s_pop_i never reaches it.
  assign full      = (count_reg == CNTW'(DEPTH));
  assign s_ready_o = ~full & ~blocked_reg;
  assign s_valid_o = (count_reg != '0);
  assign push_acc  = s_push_i & s_ready_o & ~s_flush_i;
  assign pop_acc   = s_pop_i & s_valid_o & ~s_flush_i;

  assign wr_entry = {s_payload_i, s_f_i, s_rs1_i, s_rs2_i, s_rd_i,
                     s_sctrl_i, s_ictrl_i, s_imiscon_i};

  // Storage is kept across flush; only reset clears it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [EW-1:0] entry_reg;
      always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
          entry_reg <= '0;
        end else if (push_acc && (wr_ptr_reg == PTRW'(gi))) begin
          entry_reg <= wr_entry;
        end
      end
      assign mem[gi] = entry_reg;
    end
  endgenerate

  assign head_entry = mem[rd_ptr_reg];
  assign {s_payload_o, s_f_o, s_rs1_o, s_rs2_o, s_rd_o,
          s_sctrl_o, s_ictrl_o, s_imiscon_o} = head_entry;

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      blocked_reg <= 1'b0;
    end else if (s_flush_i) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      blocked_reg <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_acc)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_acc, pop_acc})
        2'b10:   count_reg <= count_reg + CNTW'(1);
        2'b01:   count_reg <= count_reg - CNTW'(1);
        default: count_reg <= count_reg;
      endcase
      if (push_acc && (s_imiscon_i != IMISCON_FREE)) blocked_reg <= 1'b1;
    end
  end

  assign s_count_o   = count_reg;
  assign s_blocked_o = blocked_reg;

endmodule

// File: tb/tb_decode_buffer.sv
// Bench for decode_buffer: directed vector table, hand sequences for wrap and reset,
// and random traffic compared against a queue-based reference model.
module tb_decode_buffer;

  localparam int DEPTH = 4;
  localparam logic [1:0] FREE = 2'd0;
  localparam logic [1:0] ILLE = 2'd1;

  typedef struct packed {
    logic [20:0] payload;
    logic [2:0]  f;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  sctrl;
    logic [5:0]  ictrl;
    logic [1:0]  imiscon;
  } entry_t;

  typedef struct {
    bit          push;
    bit          pop;
    bit          flush;
    logic [20:0] payload;
    logic [1:0]  imiscon;
    int          exp_count;
    bit          exp_valid;
    bit          exp_ready;
    bit          exp_blocked;
    logic [20:0] exp_payload;
    logic [1:0]  exp_imiscon;
  } vec_t;

  logic clk, rst_n, flush, push, pop;
  entry_t in_e, out_e;
  logic ready_o, valid_o, blocked_o;
  logic [2:0] count_o;
  logic [20:0] payload_o;
  logic [2:0] f_o;
  logic [4:0] rs1_o, rs2_o, rd_o;
  logic [3:0] sctrl_o;
  logic [5:0] ictrl_o;
  logic [1:0] imiscon_o;

  int checks = 0;
  int errors = 0;
  entry_t mq[$];
  bit m_blocked = 0;
  vec_t tbl[21];

  decode_buffer #(.DEPTH(DEPTH), .PWIDTH(21)) dut (
    .s_clk_i(clk), .s_resetn_i(rst_n), .s_flush_i(flush), .s_push_i(push),
    .s_payload_i(in_e.payload), .s_f_i(in_e.f), .s_rs1_i(in_e.rs1), .s_rs2_i(in_e.rs2),
    .s_rd_i(in_e.rd), .s_sctrl_i(in_e.sctrl), .s_ictrl_i(in_e.ictrl),
    .s_imiscon_i(in_e.imiscon), .s_ready_o(ready_o), .s_valid_o(valid_o), .s_pop_i(pop),
    .s_payload_o(payload_o), .s_f_o(f_o), .s_rs1_o(rs1_o), .s_rs2_o(rs2_o), .s_rd_o(rd_o),
    .s_sctrl_o(sctrl_o), .s_ictrl_o(ictrl_o), .s_imiscon_o(imiscon_o),
    .s_count_o(count_o), .s_blocked_o(blocked_o)
  );

  assign out_e = {payload_o, f_o, rs1_o, rs2_o, rd_o, sctrl_o, ictrl_o, imiscon_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic entry_t rand_entry(input bit mis);
    entry_t e;
    e = entry_t'({$urandom, $urandom});
    e.imiscon = mis ? 2'(1 + $urandom_range(0, 2)) : FREE;
    return e;
  endfunction

  // Reference: a plain queue; acceptance decided from the state before the edge.
  task automatic model_step(input bit p, input bit q, input bit fl, input entry_t e);
    bit rdy, vld;
    rdy = (mq.size() < DEPTH) && !m_blocked;
    vld = (mq.size() > 0);
    if (fl) begin
      mq.delete();
      m_blocked = 0;
    end else begin
      if (q && vld) void'(mq.pop_front());
      if (p && rdy) begin
        mq.push_back(e);
        if (e.imiscon != FREE) m_blocked = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, count_o, mq.size());
    chk({tag, " valid"}, valid_o, mq.size() > 0);
    chk({tag, " ready"}, ready_o, (mq.size() < DEPTH) && !m_blocked);
    chk({tag, " blocked"}, blocked_o, m_blocked);
    if (mq.size() > 0) chk({tag, " head"}, out_e, mq[0]);
  endtask

  task automatic cycle(input bit p, input bit q, input bit fl, input entry_t e);
    push = p; pop = q; flush = fl; in_e = e;
    @(posedge clk);
    #1;
    model_step(p, q, fl, e);
    push = 0; pop = 0; flush = 0;
  endtask

  initial begin
    entry_t e;
    rst_n = 0; push = 0; pop = 0; flush = 0; in_e = '0;

    //                push pop fl  payload        imis  cnt v  r  b  exp_payload    exp_imis
    tbl[0]  = '{1, 0, 0, 21'h00000A, FREE, 1, 1, 1, 0, 21'h00000A, FREE};
    tbl[1]  = '{1, 0, 0, 21'h10000B, FREE, 2, 1, 1, 0, 21'h00000A, FREE};
    tbl[2]  = '{1, 0, 0, 21'h00000C, FREE, 3, 1, 1, 0, 21'h00000A, FREE};
    tbl[3]  = '{1, 0, 0, 21'h10000D, FREE, 4, 1, 0, 0, 21'h00000A, FREE};
    tbl[4]  = '{1, 0, 0, 21'h00000E, FREE, 4, 1, 0, 0, 21'h00000A, FREE};
    tbl[5]  = '{0, 1, 0, 21'h0,      FREE, 3, 1, 1, 0, 21'h10000B, FREE};
    tbl[6]  = '{0, 1, 0, 21'h0,      FREE, 2, 1, 1, 0, 21'h00000C, FREE};
    tbl[7]  = '{0, 1, 0, 21'h0,      FREE, 1, 1, 1, 0, 21'h10000D, FREE};
    tbl[8]  = '{0, 1, 0, 21'h0,      FREE, 0, 0, 1, 0, 21'h0,      FREE};
    tbl[9]  = '{1, 0, 0, 21'h0001A2, FREE, 1, 1, 1, 0, 21'h0001A2, FREE};
    tbl[10] = '{1, 1, 0, 21'h0001B2, FREE, 1, 1, 1, 0, 21'h0001B2, FREE};
    tbl[11] = '{0, 1, 0, 21'h0,      FREE, 0, 0, 1, 0, 21'h0,      FREE};
    tbl[12] = '{1, 0, 0, 21'h000055, ILLE, 1, 1, 0, 1, 21'h000055, ILLE};
    tbl[13] = '{1, 0, 0, 21'h000066, FREE, 1, 1, 0, 1, 21'h000055, ILLE};
    tbl[14] = '{0, 1, 0, 21'h0,      FREE, 0, 0, 0, 1, 21'h0,      FREE};
    tbl[15] = '{0, 0, 1, 21'h0,      FREE, 0, 0, 1, 0, 21'h0,      FREE};
    tbl[16] = '{1, 0, 0, 21'h000071, FREE, 1, 1, 1, 0, 21'h000071, FREE};
    tbl[17] = '{1, 0, 0, 21'h000072, FREE, 2, 1, 1, 0, 21'h000071, FREE};
    tbl[18] = '{1, 0, 0, 21'h000073, FREE, 3, 1, 1, 0, 21'h000071, FREE};
    tbl[19] = '{1, 1, 1, 21'h000074, FREE, 0, 0, 1, 0, 21'h0,      FREE};
    tbl[20] = '{0, 0, 0, 21'h0,      FREE, 0, 0, 1, 0, 21'h0,      FREE};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", count_o, 0);
    chk("reset valid", valid_o, 0);
    chk("reset ready", ready_o, 1);
    chk("reset blocked", blocked_o, 0);
    chk("reset head", out_e, 0);
    rst_n = 1;

    // Directed vectors
    for (int i = 0; i < 21; i++) begin
      e = rand_entry(0);
      e.payload = tbl[i].payload;
      e.imiscon = tbl[i].imiscon;
      cycle(tbl[i].push, tbl[i].pop, tbl[i].flush, e);
      chk($sformatf("vec%0d count", i), count_o, tbl[i].exp_count);
      chk($sformatf("vec%0d valid", i), valid_o, tbl[i].exp_valid);
      chk($sformatf("vec%0d ready", i), ready_o, tbl[i].exp_ready);
      chk($sformatf("vec%0d blocked", i), blocked_o, tbl[i].exp_blocked);
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d payload", i), payload_o, tbl[i].exp_payload);
        chk($sformatf("vec%0d imiscon", i), imiscon_o, tbl[i].exp_imiscon);
      end
    end

    // Wrap-around: ten push/pop pairs through a 4-deep buffer
    for (int i = 0; i < 10; i++) begin
      e = rand_entry(0);
      cycle(1, 0, 0, e);
      chk($sformatf("wrap%0d head", i), out_e, e);
      cycle(0, 1, 0, '0);
      check_model($sformatf("wrap%0d", i));
    end

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      e = rand_entry($urandom_range(0, 15) == 0);
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
            $urandom_range(0, 31) == 0, e);
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset with two entries buffered
    cycle(0, 0, 1, '0);
    cycle(1, 0, 0, rand_entry(0));
    cycle(1, 0, 0, rand_entry(0));
    check_model("pre-reset");
    #2;
    rst_n = 0;
    #1;
    mq.delete();
    m_blocked = 0;
    chk("async rst count", count_o, 0);
    chk("async rst valid", valid_o, 0);
    chk("async rst ready", ready_o, 1);
    chk("async rst blocked", blocked_o, 0);
    chk("async rst head", out_e, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    e = rand_entry(0);
    cycle(1, 0, 0, e);
    check_model("post-reset push");
    chk("post-reset head", out_e, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
